// File: rtl/cxu_hash_pkg.sv
// Shared opcodes, FSM state type and derived-constant helper for the hash/rolling-sum CXU.
package cxu_hash_pkg;

    localparam logic [2:0] OP_HASH1   = 3'd0;
    localparam logic [2:0] OP_ROLL1   = 3'd1;
    localparam logic [2:0] OP_HASH_N  = 3'd2;
    localparam logic [2:0] OP_ROLL4   = 3'd3;
    localparam logic [2:0] OP_CTX_WR  = 3'd4;
    localparam logic [2:0] OP_CTX_RD  = 3'd5;
    localparam logic [2:0] OP_CLR_ALL = 3'd6;
    localparam logic [2:0] OP_RSVD    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP
    } state_t;

    // Shift that spreads MIN_MATCH bytes across the full hash width.
    function automatic int h_shift(input int hash_bits, input int min_match);
        return (hash_bits + min_match - 1) / min_match;
    endfunction

endpackage

// File: rtl/cxu_hash_byte_step.sv
// One-byte combinational step: LZ hash update and rolling-sum add/subtract.
module cxu_hash_byte_step #(
    parameter int HASH_BITS = 15,
    parameter int H_SHIFT   = 5
) (
    input  logic [HASH_BITS-1:0] hash_in,
    input  logic [31:0]          sum_in,
    input  logic [7:0]           new_b,
    input  logic [7:0]           old_b,
    output logic [HASH_BITS-1:0] hash_out,
    output logic [31:0]          sum_out
);

    logic [HASH_BITS-1:0] shifted;

    // The shift is truncated to HASH_BITS, which applies the hash mask for free.
    assign shifted  = hash_in << H_SHIFT;
    assign hash_out = shifted ^ HASH_BITS'(new_b);
    assign sum_out  = sum_in + 32'(new_b) - 32'(old_b);

endmodule

// File: rtl/cxu_hash_ctx_engine.sv
// Multi-context LZ-hash / rolling-checksum CXU with valid/ready cmd and rsp channels.
module cxu_hash_ctx_engine
    import cxu_hash_pkg::*;
#(
    parameter int HASH_BITS = 15,
    parameter int MIN_MATCH = 3,
    parameter int NUM_CTX   = 8,
    parameter int SUM_W     = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    input  logic [2:0]  cmd_payload_state_id,
    input  logic [3:0]  cmd_payload_cxu_id,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int H_SHIFT = h_shift(HASH_BITS, MIN_MATCH);
    localparam int IDX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

    logic [1:0]           rst_pipe;
    logic                 rst_sync_n;
    state_t               state, state_nxt;
    logic [2:0]           op_q;
    logic [31:0]          a_q, b_q;
    logic [IDX_W-1:0]     sid_q;
    logic [2:0]           cnt_q;
    logic [1:0]           idx_q;
    logic                 bad_q;
    logic [HASH_BITS-1:0] run_hash;
    logic [31:0]          run_sum;
    logic [31:0]          rsp_q;
    logic [HASH_BITS-1:0] ctx_hash [NUM_CTX];
    logic [SUM_W-1:0]     ctx_sum  [NUM_CTX];

    logic                 accept, sid_ok, is_ctx_op, multi;
    logic [IDX_W-1:0]     sid_idx;
    logic [2:0]           n_req, n_bytes;
    logic [31:0]          imm_rsp;
    logic [HASH_BITS-1:0] step_hash_in, step_hash_out;
    logic [31:0]          step_sum_in, step_sum_out;
    logic [7:0]           step_new_b, step_old_b;
    logic                 unused_inputs;

    assign unused_inputs = ^{cmd_payload_cxu_id, cmd_payload_state_id};

    // Reset asserts immediately but releases two clocks later on a clean edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_sync_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        case (state)
            ST_IDLE: if (accept) state_nxt = multi ? ST_RUN : ST_RESP;
            ST_RUN:  if (cnt_q == 3'd1) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept    = cmd_valid && cmd_ready;
    assign sid_idx   = cmd_payload_state_id[IDX_W-1:0];
    assign sid_ok    = int'(cmd_payload_state_id) < NUM_CTX;
    assign is_ctx_op = cmd_payload_function_id inside {OP_HASH_N, OP_ROLL4, OP_CTX_WR, OP_CTX_RD};
    assign multi     = (is_ctx_op && !sid_ok) || (cmd_payload_function_id == OP_HASH_N)
                       || (cmd_payload_function_id == OP_ROLL4);
    assign n_req     = cmd_payload_inputs_0[2:0];

    // A bad context index takes the one-byte path so it still costs a RUN cycle.
    always_comb begin
        n_bytes = 3'd4;
        if (is_ctx_op && !sid_ok) n_bytes = 3'd1;
        else if (cmd_payload_function_id == OP_HASH_N && n_req != 3'd0 && n_req <= 3'd4) n_bytes = n_req;
    end

    always_comb begin
        step_hash_in = HASH_BITS'(cmd_payload_inputs_0);
        step_sum_in  = cmd_payload_inputs_0;
        step_new_b   = cmd_payload_inputs_1[7:0];
        step_old_b   = cmd_payload_inputs_1[15:8];
        if (state == ST_RUN) begin
            step_hash_in = run_hash;
            step_sum_in  = run_sum;
            step_new_b   = (op_q == OP_HASH_N) ? b_q[8*idx_q +: 8] : a_q[8*idx_q +: 8];
            step_old_b   = b_q[8*idx_q +: 8];
        end
    end

    cxu_hash_byte_step #(
        .HASH_BITS (HASH_BITS),
        .H_SHIFT   (H_SHIFT)
    ) u_step (
        .hash_in  (step_hash_in),
        .sum_in   (step_sum_in),
        .new_b    (step_new_b),
        .old_b    (step_old_b),
        .hash_out (step_hash_out),
        .sum_out  (step_sum_out)
    );

    always_comb begin
        imm_rsp = 32'd0;
        case (cmd_payload_function_id)
            OP_HASH1:  imm_rsp = 32'(step_hash_out);
            OP_ROLL1:  imm_rsp = step_sum_out;
            OP_CTX_RD: imm_rsp = cmd_payload_inputs_0[0] ? 32'(ctx_sum[sid_idx]) : 32'(ctx_hash[sid_idx]);
            default:   imm_rsp = 32'd0;
        endcase
    end

    // Running values are committed on the last RUN cycle so the next command sees them.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sid_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            bad_q    <= 1'b0;
            run_hash <= '0;
            run_sum  <= '0;
            rsp_q    <= '0;
            for (int i = 0; i < NUM_CTX; i++) begin
                ctx_hash[i] <= '0;
                ctx_sum[i]  <= '0;
            end
        end else if (accept) begin
            op_q     <= cmd_payload_function_id;
            a_q      <= cmd_payload_inputs_0;
            b_q      <= cmd_payload_inputs_1;
            sid_q    <= sid_idx;
            cnt_q    <= n_bytes;
            idx_q    <= 2'd0;
            bad_q    <= is_ctx_op && !sid_ok;
            run_hash <= sid_ok ? ctx_hash[sid_idx] : '0;
            run_sum  <= sid_ok ? 32'(ctx_sum[sid_idx]) : 32'd0;
            if (!multi) begin
                rsp_q <= imm_rsp;
                if (cmd_payload_function_id == OP_CTX_WR) begin
                    ctx_hash[sid_idx] <= HASH_BITS'(cmd_payload_inputs_0);
                    ctx_sum[sid_idx]  <= SUM_W'(cmd_payload_inputs_1);
                end
                if (cmd_payload_function_id == OP_CLR_ALL) begin
                    for (int i = 0; i < NUM_CTX; i++) begin
                        ctx_hash[i] <= '0;
                        ctx_sum[i]  <= '0;
                    end
                end
            end
        end else if (state == ST_RUN) begin
            run_hash <= step_hash_out;
            run_sum  <= step_sum_out;
            idx_q    <= idx_q + 2'd1;
            cnt_q    <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                if (bad_q) begin
                    rsp_q <= 32'd0;
                end else if (op_q == OP_HASH_N) begin
                    ctx_hash[sid_q] <= step_hash_out;
                    rsp_q           <= 32'(step_hash_out);
                end else begin
                    ctx_sum[sid_q] <= SUM_W'(step_sum_out);
                    rsp_q          <= 32'(SUM_W'(step_sum_out));
                end
            end
        end
    end

    assign rsp_payload_outputs_0 = rsp_q;

endmodule
